// File: rtl/eval_inverse_pipe.sv
// Readback-side inverse of the forward evaluator: recovers data_in2 from a forward
// result plus the data_in1/kernel_enable that produced it, through a 2-stage valid/ready pipe.
module eval_inverse_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_result,
    input  logic [7:0]       in_data1,
    input  logic             in_kernel_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data2,
    output logic [7:0]       out_data1,
    output logic [CNT_W-1:0] decode_count,
    output logic             busy
);

    function automatic logic [7:0] kernel_term(input logic ke, input logic [3:0] addr);
        logic [7:0] rom;
        case (addr)
            4'd0:    rom = 8'd57;
            4'd1:    rom = 8'd61;
            4'd2:    rom = 8'd22;
            4'd3:    rom = 8'd98;
            4'd4:    rom = 8'd121;
            4'd5:    rom = 8'd17;
            4'd6:    rom = 8'd13;
            default: rom = 8'd3;
        endcase
        return ke ? rom : 8'd0;
    endfunction

    // result = sub + ~d2, so ~(result - sub) yields d2 with all wrap discarded
    function automatic logic [7:0] recover(input logic [7:0] result, input logic [7:0] sub);
        logic [7:0] diff;
        diff = result - sub;
        return ~diff;
    endfunction

    logic             s1_en, s2_en;
    logic             vld_p1_q, vld_p1_d;
    logic [7:0]       result_p1_q, result_p1_d;
    logic [7:0]       data1_p1_q, data1_p1_d;
    logic [7:0]       sub_p1_q, sub_p1_d;
    logic             vld_p2_q, vld_p2_d;
    logic [7:0]       data2_p2_q, data2_p2_d;
    logic [7:0]       data1_p2_q, data1_p2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        s2_en       = !vld_p2_q || out_ready;
        s1_en       = !vld_p1_q || s2_en;
        vld_p1_d    = vld_p1_q;
        result_p1_d = result_p1_q;
        data1_p1_d  = data1_p1_q;
        sub_p1_d    = sub_p1_q;
        vld_p2_d    = vld_p2_q;
        data2_p2_d  = data2_p2_q;
        data1_p2_d  = data1_p2_q;
        cnt_d       = cnt_q;

        // stage 1: capture operands and precompute the forward-side subtrahend
        if (s1_en) begin
            vld_p1_d = in_valid;
            if (in_valid) begin
                result_p1_d = in_result;
                data1_p1_d  = in_data1;
                sub_p1_d    = kernel_term(in_kernel_en, in_data1[3:0]) + in_data1;
            end
        end

        // stage 2: recover data_in2
        if (s2_en) begin
            vld_p2_d = vld_p1_q;
            if (vld_p1_q) begin
                data2_p2_d = recover(result_p1_q, sub_p1_q);
                data1_p2_d = data1_p1_q;
            end
        end

        if (vld_p2_q && out_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1_q    <= 1'b0;
            result_p1_q <= '0;
            data1_p1_q  <= '0;
            sub_p1_q    <= '0;
            vld_p2_q    <= 1'b0;
            data2_p2_q  <= '0;
            data1_p2_q  <= '0;
            cnt_q       <= '0;
        end else begin
            vld_p1_q    <= vld_p1_d;
            result_p1_q <= result_p1_d;
            data1_p1_q  <= data1_p1_d;
            sub_p1_q    <= sub_p1_d;
            vld_p2_q    <= vld_p2_d;
            data2_p2_q  <= data2_p2_d;
            data1_p2_q  <= data1_p2_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready     = s1_en;
    assign out_valid    = vld_p2_q;
    assign out_data2    = data2_p2_q;
    assign out_data1    = data1_p2_q;
    assign decode_count = cnt_q;
    assign busy         = vld_p1_q || vld_p2_q;

endmodule

// File: tb/tb_eval_inverse_pipe.sv
// Scoreboard bench for eval_inverse_pipe: the driver queues the expected word on each
// accept, an independent monitor pops and compares on each output handshake.
module tb_eval_inverse_pipe;

    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_result;
    logic [7:0]       in_data1;
    logic             in_kernel_en;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data2;
    logic [7:0]       out_data1;
    logic [CNT_W-1:0] decode_count;
    logic             busy;

    logic             rmode;
    logic             stall;
    logic             rnd;
    logic [15:0]      sb[$];
    int               total;
    int               passed;
    logic [CNT_W-1:0] exp_cnt;
    logic             saw_stall;
    logic             prev_hold;
    logic [7:0]       prev_d2, prev_d1;

    eval_inverse_pipe #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_data1(in_data1), .in_kernel_en(in_kernel_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data2(out_data2), .out_data1(out_data1),
        .decode_count(decode_count), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign out_ready = rmode ? rnd : !stall;

    always @(negedge clk) rnd = 1'($urandom_range(0, 1));

    function automatic logic [7:0] model_rom(input logic [3:0] a);
        case (a)
            4'd0: return 8'd57;
            4'd1: return 8'd61;
            4'd2: return 8'd22;
            4'd3: return 8'd98;
            4'd4: return 8'd121;
            4'd5: return 8'd17;
            4'd6: return 8'd13;
            default: return 8'd3;
        endcase
    endfunction

    function automatic logic [7:0] forward(input logic [7:0] d1, input logic [7:0] d2, input logic ke);
        logic [7:0] nd2;
        nd2 = ~d2;
        return (ke ? model_rom(d1[3:0]) : 8'd0) + nd2 + d1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Presents one word from a negedge; returns on the negedge after it is accepted.
    task automatic send(input logic [7:0] d1, input logic [7:0] res, input logic ke,
                        input logic [7:0] exp2);
        int  g;
        bit  done;
        g    = 0;
        done = 0;
        in_valid     = 1'b1;
        in_data1     = d1;
        in_result    = res;
        in_kernel_en = ke;
        while (!done) begin
            #4;
            if (in_ready) begin
                sb.push_back({exp2, d1});
                done = 1;
            end else begin
                saw_stall = 1'b1;
                g++;
                if (g > 500) begin
                    check("send_timeout", 32'd1, 32'd0);
                    done = 1;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        in_valid = 1'b0;
        while ((sb.size() != 0 || busy) && g < 5000) begin
            @(negedge clk);
            g++;
        end
        check("drain_done", 32'(sb.size() == 0 && !busy), 32'd1);
    endtask

    // Monitor: sampled one time unit before each rising edge.
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    check("hold_valid", 32'(out_valid), 32'd1);
                    check("hold_d2", 32'(out_data2), 32'(prev_d2));
                    check("hold_d1", 32'(out_data1), 32'(prev_d1));
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_output", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("out_data2", 32'(out_data2), 32'(e[15:8]));
                        check("out_data1", 32'(out_data1), 32'(e[7:0]));
                    end
                    exp_cnt = exp_cnt + CNT_W'(1);
                end
                prev_hold = out_valid && !out_ready;
                prev_d2   = out_data2;
                prev_d1   = out_data1;
            end
        end
    end

    initial begin
        logic [7:0]       d1, d2;
        logic             ke;
        logic [CNT_W-1:0] base;
        total = 0; passed = 0; exp_cnt = '0; saw_stall = 1'b0; prev_hold = 1'b0;
        prev_d2 = '0; prev_d1 = '0;
        rmode = 1'b0; stall = 1'b0;
        in_valid = 1'b0; in_result = '0; in_data1 = '0; in_kernel_en = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(decode_count), 32'd0);
        check("rst_data2", 32'(out_data2), 32'd0);
        check("rst_data1", 32'(out_data1), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // Directed vectors with hand-computed expectations
        send(8'h05, 8'h05, 1'b1, 8'h10);
        in_valid = 1'b0;
        #4 check("lat1_not_yet", 32'(out_valid), 32'd0);
        @(negedge clk);
        #1 check("lat2_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        send(8'h20, 8'hEC, 1'b0, 8'h33);
        send(8'hFA, 8'hFC, 1'b1, 8'h00);
        drain();
        check("count_directed", 32'(decode_count), 32'd3);

        // 8-word stream with downstream stalled for four cycles
        base = decode_count;
        saw_stall = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    d2 = 8'(8'h11 * i + 8'h07);
                    d1 = 8'(8'h1F * i);
                    ke = 1'(i % 2);
                    send(d1, forward(d1, d2, ke), ke, d2);
                end
                in_valid = 1'b0;
            end
            begin
                repeat (2) @(negedge clk);
                stall = 1'b1;
                repeat (4) @(negedge clk);
                stall = 1'b0;
            end
        join
        drain();
        check("stream_in_ready_dropped", 32'(saw_stall), 32'd1);
        check("stream_count", 32'(decode_count - base), 32'd8);

        // Random forward-model words under random backpressure
        rmode = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            d1 = 8'($urandom);
            d2 = 8'($urandom);
            ke = 1'($urandom_range(0, 1));
            send(d1, forward(d1, d2, ke), ke, d2);
            if ($urandom_range(0, 7) == 0) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
        end
        rmode = 1'b0;
        drain();
        check("random_count", 32'(decode_count), 32'(exp_cnt));

        // Asynchronous reset with both stages full
        stall = 1'b1;
        send(8'h01, forward(8'h01, 8'hAA, 1'b1), 1'b1, 8'hAA);
        send(8'h02, forward(8'h02, 8'h55, 1'b0), 1'b0, 8'h55);
        in_valid = 1'b0;
        @(negedge clk);
        check("full_busy", 32'(busy), 32'd1);
        check("full_in_ready", 32'(in_ready), 32'd0);
        #2 rst = 1'b1;
        sb.delete();
        exp_cnt = '0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_count", 32'(decode_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        send(8'h33, forward(8'h33, 8'h9C, 1'b1), 1'b1, 8'h9C);
        in_valid = 1'b0;
        #4 check("post_rst_lat1", 32'(out_valid), 32'd0);
        @(negedge clk);
        #1 check("post_rst_lat2", 32'(out_valid), 32'd1);
        @(negedge clk);
        drain();
        check("post_rst_count", 32'(decode_count), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
